hyperbus_wb_bridge: RTL

HYPERBUS_WB_BRIDGE -- requirements
Module: hyperbus_wb_bridge

---
 rtl/hyperbus_wb_bridge.sv | 96 +++++++++
 1 files changed

// File: rtl/hyperbus_wb_bridge.sv
// hyperbus_wb_bridge: Wishbone classic slave that forwards single 32-bit word accesses to a HyperBus controller
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i       Wishbone cycle / strobe
//   wb_we_i, wb_adr_i        direction (1 = write) and byte address
//   wb_dat_i, wb_sel_i       write data and byte selects (only 4'b1111 accepted)
//   wb_dat_o                 registered read data
//   wb_ack_o, wb_err_o       single-cycle termination pulses
//   hb_addr, hb_wdata        address / write data held for the controller
//   hb_rdata                 read data from the controller
//   hb_wrq, hb_rrq           single-cycle write / read request pulses
//   hb_busy                  controller busy
module hyperbus_wb_bridge #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [31:0] hb_addr,
    output logic [31:0] hb_wdata,
    input  logic [31:0] hb_rdata,
    output logic        hb_wrq,
    output logic        hb_rrq,
    input  logic        hb_busy
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT_START, WAIT_DONE, RESP} state_t;
    // The counter is compared one below its terminal value because the
    // transition to RESP happens on the same edge that it reaches TIMEOUT-1.
    localparam logic [31:0] LP_TMO_LAST = 32'(TIMEOUT - 2);
    state_t      r_state, w_next;
    logic        r_we, r_drop;
    logic [31:0] r_cnt;
    logic        w_strobe, w_accept, w_sel_err, w_in_txn, w_waiting, w_drop;
    logic        w_tmo, w_done, w_ack_nxt, w_err_nxt;
    always_comb begin
        // A strobe still high during our own ack/err cycle belongs to the
        // finished access, so it is ignored.
        w_strobe  = wb_cyc_i & wb_stb_i & ~(wb_ack_o | wb_err_o);
        w_sel_err = (r_state == IDLE) & w_strobe & (wb_sel_i != 4'hF);
        w_accept  = (r_state == IDLE) & w_strobe & (wb_sel_i == 4'hF) & ~hb_busy;
        w_waiting = (r_state == WAIT_START) | (r_state == WAIT_DONE);
        w_in_txn  = (r_state == REQ) | w_waiting;
        w_drop    = r_drop | (w_in_txn & ~wb_cyc_i);
        w_done    = (r_state == WAIT_DONE) & ~hb_busy;
        // Timeout only when the current wait state is not being left anyway.
        w_tmo     = (((r_state == WAIT_START) & ~hb_busy) | ((r_state == WAIT_DONE) & hb_busy))
                    & (r_cnt == LP_TMO_LAST);
        w_ack_nxt = w_done & ~w_drop;
        w_err_nxt = w_sel_err | (w_tmo & ~w_drop);
        w_next    = r_state;
        case (r_state)
            IDLE:       w_next = w_accept ? REQ : IDLE;
            REQ:        w_next = WAIT_START;
            WAIT_START: w_next = hb_busy ? WAIT_DONE : (w_tmo ? RESP : WAIT_START);
            WAIT_DONE:  w_next = (w_done | w_tmo) ? RESP : WAIT_DONE;
            RESP:       w_next = IDLE;
            default:    w_next = IDLE;
        endcase
    end
    assign hb_wrq = (r_state == REQ) & r_we;
    assign hb_rrq = (r_state == REQ) & ~r_we;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_we     <= 1'b0;
            r_drop   <= 1'b0;
            r_cnt    <= '0;
            hb_addr  <= '0;
            hb_wdata <= '0;
            wb_dat_o <= '0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
        end else begin
            r_state  <= w_next;
            wb_ack_o <= w_ack_nxt;
            wb_err_o <= w_err_nxt;
            r_drop   <= w_accept ? 1'b0 : w_drop;
            r_cnt    <= w_accept ? '0 : (w_waiting ? r_cnt + 32'd1 : r_cnt);
            if (w_accept) begin
                hb_addr  <= wb_adr_i;
                hb_wdata <= wb_dat_i;
                r_we     <= wb_we_i;
            end
            if (w_done & ~r_we)
                wb_dat_o <= hb_rdata;
        end
    end
endmodule
